mod_updown_counter: RTL

Parametrised modulo-N up/down counter with load, synchronous clear, wrap or saturate mode, and a cascade terminal-count output.
- Supersedes the fixed mod-60 counter; default parameters reproduce that block's count behaviour.
- Instances chain into multi-digit timers (seconds -> minutes -> hours) by driving each stage's CE from the previous stage's TC.

---
 rtl/mod_updown_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with range-checked load, synchronous clear, wrap or
// saturate at the bounds, and a combinational terminal count for cascading stages.
module mod_updown_counter #(
   parameter int WIDTH    = 8,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 59,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic             CLR,
   input  logic             LD,
   input  logic             Up_Down,
   input  logic [WIDTH-1:0] Count_In,
   output logic [WIDTH-1:0] Count_Out,
   output logic             TC,
   output logic             WRAP,
   output logic             LD_ERR
);

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
   localparam bit MAX_IS_TOP = (longint'(MAX_VAL) == ((longint'(1) << WIDTH) - 1));

   logic [WIDTH-1:0] count_reg, count_next;
   logic             wrap_reg, wrap_next;
   logic             ld_err_reg, ld_err_next;

   logic in_below, in_above;
   logic cnt_below, cnt_above;
   logic at_max, at_min;

   // Bound comparisons that are constant for the chosen parameters are tied off
   // here so the datapath never contains a degenerate compare.
   generate
      if (MIN_VAL == 0) begin : g_min_zero
         assign in_below  = 1'b0;
         assign cnt_below = 1'b0;
      end else begin : g_min_cmp
         assign in_below  = (Count_In < MIN_V);
         assign cnt_below = (count_reg < MIN_V);
      end

      if (MAX_IS_TOP) begin : g_max_top
         assign in_above  = 1'b0;
         assign cnt_above = 1'b0;
      end else begin : g_max_cmp
         assign in_above  = (Count_In > MAX_V);
         assign cnt_above = (count_reg > MAX_V);
      end
   endgenerate

   assign at_max = (count_reg == MAX_V);
   assign at_min = (count_reg == MIN_V);

   always_comb begin
      count_next  = count_reg;
      wrap_next   = 1'b0;
      ld_err_next = 1'b0;
      if (CLR) begin
         count_next = MIN_V;
      end else if (CE && LD) begin
         if (in_above) begin
            count_next  = MAX_V;
            ld_err_next = 1'b1;
         end else if (in_below) begin
            count_next  = MIN_V;
            ld_err_next = 1'b1;
         end else begin
            count_next = Count_In;
         end
      end else if (CE) begin
         if (cnt_above || cnt_below) begin
            count_next = MIN_V;
         end else if (Up_Down) begin
            if (!at_max) begin
               count_next = count_reg + 1'b1;
            end else if (SATURATE == 0) begin
               count_next = MIN_V;
               wrap_next  = 1'b1;
            end
         end else begin
            if (!at_min) begin
               count_next = count_reg - 1'b1;
            end else if (SATURATE == 0) begin
               count_next = MAX_V;
               wrap_next  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_reg  <= MIN_V;
         wrap_reg   <= 1'b0;
         ld_err_reg <= 1'b0;
      end else begin
         count_reg  <= count_next;
         wrap_reg   <= wrap_next;
         ld_err_reg <= ld_err_next;
      end
   end

   assign Count_Out = count_reg;
   assign WRAP      = wrap_reg;
   assign LD_ERR    = ld_err_reg;

   // Zero-latency so a downstream stage steps on the same edge this one wraps.
   assign TC = CE & ~LD & ~CLR & ((Up_Down & at_max) | (~Up_Down & at_min));

endmodule
